lane_scheduler: RTL

Time-multiplexed controller that sequences all road-lane car positions for the Frogger playfield through one shared step datapath. A round-robin pointer serves one lane per clock. Each service advances that lane's speed counter, and moves its car one pixel when the lane's level-scaled divisor is reached, with wrap-around. It sits between game-state control (start/pause/stop/level) and the sprite renderer, which reads the per-lane X positions.

---
 rtl/frogger_pkg.sv | 26 ++
 rtl/lane_scheduler_if.sv | 29 ++
 rtl/lane_stepper.sv | 19 +
 rtl/lane_scheduler.sv | 142 ++++++++++++++
 4 files changed

// File: rtl/frogger_pkg.sv
// Shared definitions for the Frogger playfield blocks: scheduler states,
// display geometry and lane direction helpers.
package frogger_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LOAD   = 2'd1,
        ST_RUN    = 2'd2,
        ST_PAUSED = 2'd3
    } lane_state_e;

    localparam int   H_DISPLAY_DEF  = 640;
    localparam int   X_W            = 10;
    localparam logic LANE_DIR_RIGHT = 1'b1;

    // Even lanes travel right, odd lanes travel left.
    function automatic logic lane_dir(input int unsigned lane);
        return lane[0] ? ~LANE_DIR_RIGHT : LANE_DIR_RIGHT;
    endfunction

    function automatic logic [X_W-1:0] lane_home(input int unsigned lane,
                                                 input int unsigned spacing);
        return X_W'(lane * spacing);
    endfunction

endpackage

// File: rtl/lane_scheduler_if.sv
// Control and position bus between game-state control, the lane scheduler
// and the sprite renderer.
interface lane_scheduler_if #(
    parameter int NUM_LANES = 4,
    parameter int DIV_W     = 24
);
    // No backpressure: every control input is sampled on each rising clock
    // edge and always accepted; outputs are registered and valid every cycle.
    logic                                  i_Start;
    logic                                  i_Pause;
    logic                                  i_Stop;
    logic [2:0]                            i_Level;
    logic [DIV_W-1:0]                      i_Base_Div;
    logic [NUM_LANES*frogger_pkg::X_W-1:0] o_Car_X;
    logic [NUM_LANES-1:0]                  o_Step;
    logic                                  o_Running;
    frogger_pkg::lane_state_e              o_State;
    logic [2:0]                            o_Ptr;

    modport master (
        output i_Start, i_Pause, i_Stop, i_Level, i_Base_Div,
        input  o_Car_X, o_Step, o_Running, o_State, o_Ptr
    );

    modport slave (
        input  i_Start, i_Pause, i_Stop, i_Level, i_Base_Div,
        output o_Car_X, o_Step, o_Running, o_State, o_Ptr
    );
endinterface

// File: rtl/lane_stepper.sv
// One-pixel horizontal move with wrap-around at both playfield edges.
module lane_stepper
    import frogger_pkg::*;
#(
    parameter int H_DISPLAY = H_DISPLAY_DEF
) (
    input  logic [X_W-1:0] i_X,
    input  logic           i_Dir_Right,
    output logic [X_W-1:0] o_X_Next
);
    always_comb begin
        o_X_Next = i_X;
        if (i_Dir_Right) begin
            o_X_Next = (i_X == X_W'(H_DISPLAY - 1)) ? '0 : i_X + X_W'(1);
        end else begin
            o_X_Next = (i_X == '0) ? X_W'(H_DISPLAY - 1) : i_X - X_W'(1);
        end
    end
endmodule

// File: rtl/lane_scheduler.sv
// Round-robin lane scheduler: one lane per clock is loaded or serviced
// through a single shared stepper; per-lane counters set the car speed.
module lane_scheduler
    import frogger_pkg::*;
#(
    parameter int NUM_LANES = 4,
    parameter int H_DISPLAY = H_DISPLAY_DEF,
    parameter int DIV_W     = 24
) (
    input  logic             i_Clk,
    input  logic             i_Rst,
    lane_scheduler_if.slave  bus
);
    localparam int                PTR_W   = $clog2(NUM_LANES);
    localparam int                SPACING = H_DISPLAY / NUM_LANES;
    localparam logic [PTR_W-1:0]  LAST    = PTR_W'(NUM_LANES - 1);

    lane_state_e          state_q, state_d;
    logic [PTR_W-1:0]     ptr_q, ptr_d;
    logic [DIV_W-1:0]     cnt_q [NUM_LANES];
    logic [DIV_W-1:0]     cnt_d [NUM_LANES];
    logic [X_W-1:0]       x_q   [NUM_LANES];
    logic [X_W-1:0]       x_d   [NUM_LANES];
    logic [NUM_LANES-1:0] step_q, step_d;
    logic                 running_q, running_d;

    logic [DIV_W-1:0]     eff_raw, eff;
    logic [DIV_W:0]       cnt_inc;
    logic                 due;
    logic [X_W-1:0]       x_cur, x_next;
    logic                 dir_cur;

    // Shared service datapath, muxed onto the lane selected by the pointer.
    always_comb begin
        eff_raw = bus.i_Base_Div >> bus.i_Level;
        eff     = (eff_raw == '0) ? DIV_W'(1) : eff_raw;
        cnt_inc = {1'b0, cnt_q[ptr_q]} + (DIV_W + 1)'(1);
        due     = (cnt_inc >= {1'b0, eff});
        x_cur   = x_q[ptr_q];
        dir_cur = lane_dir(32'(ptr_q));
    end

    lane_stepper #(.H_DISPLAY(H_DISPLAY)) u_stepper (
        .i_X         (x_cur),
        .i_Dir_Right (dir_cur),
        .o_X_Next    (x_next)
    );

    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) state_q <= ST_IDLE;
        else       state_q <= state_d;
    end

    // Stop beats pause beats start.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   if (bus.i_Start) state_d = ST_LOAD;
            ST_LOAD: begin
                if (bus.i_Stop)          state_d = ST_IDLE;
                else if (ptr_q == LAST)  state_d = ST_RUN;
            end
            ST_RUN: begin
                if (bus.i_Stop)          state_d = ST_IDLE;
                else if (bus.i_Pause)    state_d = ST_PAUSED;
            end
            ST_PAUSED: begin
                if (bus.i_Stop)          state_d = ST_IDLE;
                else if (!bus.i_Pause)   state_d = ST_RUN;
            end
            default:                     state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        ptr_d     = ptr_q;
        cnt_d     = cnt_q;
        x_d       = x_q;
        step_d    = '0;
        running_d = (state_q == ST_RUN) && (state_d == ST_RUN);
        case (state_q)
            ST_IDLE: begin
                if (state_d == ST_LOAD) ptr_d = '0;
            end
            ST_LOAD: begin
                if (state_d == ST_IDLE) begin
                    ptr_d = '0;
                end else begin
                    x_d[ptr_q]   = lane_home(32'(ptr_q), SPACING);
                    cnt_d[ptr_q] = '0;
                    ptr_d        = (ptr_q == LAST) ? '0 : ptr_q + PTR_W'(1);
                end
            end
            ST_RUN: begin
                if (state_d == ST_IDLE) begin
                    ptr_d = '0;
                end else if (state_d == ST_RUN) begin
                    if (due) begin
                        cnt_d[ptr_q]  = '0;
                        x_d[ptr_q]    = x_next;
                        step_d[ptr_q] = 1'b1;
                    end else begin
                        cnt_d[ptr_q]  = cnt_inc[DIV_W-1:0];
                    end
                    ptr_d = (ptr_q == LAST) ? '0 : ptr_q + PTR_W'(1);
                end
            end
            ST_PAUSED: begin
                if (state_d == ST_IDLE) ptr_d = '0;
            end
            default: ptr_d = '0;
        endcase
    end

    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) begin
            ptr_q     <= '0;
            step_q    <= '0;
            running_q <= 1'b0;
            for (int k = 0; k < NUM_LANES; k++) begin
                cnt_q[k] <= '0;
                x_q[k]   <= '0;
            end
        end else begin
            ptr_q     <= ptr_d;
            step_q    <= step_d;
            running_q <= running_d;
            cnt_q     <= cnt_d;
            x_q       <= x_d;
        end
    end

    for (genvar k = 0; k < NUM_LANES; k++) begin : g_car_x
        assign bus.o_Car_X[k*X_W +: X_W] = x_q[k];
    end

    assign bus.o_Step    = step_q;
    assign bus.o_Running = running_q;
    assign bus.o_State   = state_q;
    assign bus.o_Ptr     = 3'(ptr_q);

endmodule
